// File: rtl/axil_reg_pkg.sv
// Shared types and constants for the AXI4-Lite register slave.
// Response codes, write/read FSM state enums, data/strobe widths, the
// write-beat payload struct, and the byte-strobe-to-bit-mask helper.
// Optional build macro AXIL_REG_STICKY_STATUS_EN is consumed by
// axil_reg_slave and axil_reg_bank, not by this package.
package axil_reg_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = DATA_W / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_HAVE_ADDR,
        W_HAVE_DATA,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_RESP
    } rd_state_t;

    // One write-data beat as seen on the W channel
    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
    } wr_beat_t;

    // Expand byte strobes into a per-bit write mask
    function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int unsigned k = 0; k < STRB_W; k++) begin
            m[8*k +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axil_reg_bank.sv
// Register storage for the AXI4-Lite register slave.
// Holds NUM_REGS byte-strobed R/W registers, generates one-cycle write
// pulses, and provides the status word seen by reads at index NUM_REGS.
// With AXIL_REG_STICKY_STATUS_EN defined the status word is a sticky
// register (set by hw_status_in, W1C by writes); otherwise it is the live
// hw_status_in value.
// Ports:
//   aclk, areset    clock, synchronous active-high reset
//   wr_en           write commit strobe (one cycle per completed write)
//   wr_idx, wr_beat word index and data/strobe of the committed write
//   hw_status_in    hardware status input
//   reg_out         flattened register contents, reg i at [32*i +: 32]
//   reg_wr_pulse    one-cycle strobe per register written
//   status_rd_c     status word value presented to the read path
module axil_reg_bank
    import axil_reg_pkg::*;
#(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned IDX_W    = 10
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic                       wr_en,
    input  logic [IDX_W-1:0]           wr_idx,
    input  wr_beat_t                   wr_beat,
    input  logic [DATA_W-1:0]          hw_status_in,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        reg_wr_pulse,
    output logic [DATA_W-1:0]          status_rd_c
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] pulse_q;
    logic [NUM_REGS-1:0] pulse_d;
    logic [DATA_W-1:0]   mask_c;

    assign mask_c = strb_mask(wr_beat.strb);

    // Byte-strobe merge and pulse generation for the addressed register
    always_comb begin
        pulse_d = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                regs_d[i]  = (regs_q[i] & ~mask_c) | (wr_beat.data & mask_c);
                pulse_d[i] = |wr_beat.strb;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            pulse_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            pulse_q <= pulse_d;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign reg_out[DATA_W*g +: DATA_W] = regs_q[g];
    end

    assign reg_wr_pulse = pulse_q;

`ifdef AXIL_REG_STICKY_STATUS_EN
    logic [DATA_W-1:0] status_q;
    logic [DATA_W-1:0] status_d;
    logic [DATA_W-1:0] clr_c;

    // Sticky status: OR in hardware bits every cycle, W1C on writes; set wins
    always_comb begin
        clr_c = '0;
        if (wr_en && (wr_idx == IDX_W'(NUM_REGS))) begin
            clr_c = wr_beat.data & mask_c;
        end
        status_d = (status_q & ~clr_c) | hw_status_in;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign status_rd_c = status_q;
`else
    assign status_rd_c = hw_status_in;
`endif

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite slave endpoint terminating master transactions onto a bank of
// NUM_REGS 32-bit R/W control registers plus one status word at index
// NUM_REGS. Independent write (AW/W/B) and read (AR/R) FSMs; register
// storage lives in axil_reg_bank.
// Build macro: AXIL_REG_STICKY_STATUS_EN makes the status word sticky/W1C
// and status writes return OKAY; when undefined status reads are live and
// status writes return SLVERR.
// Ports:
//   aclk, areset          clock, synchronous active-high reset
//   s_axil_aw*/w*/b*      AXI4-Lite write address, data, response channels
//   s_axil_ar*/r*         AXI4-Lite read address and data channels
//   reg_out               flattened register contents
//   reg_wr_pulse          one-cycle strobe per register written
//   hw_status_in          hardware status word
module axil_reg_slave
    import axil_reg_pkg::*;
#(
    parameter int unsigned ADDR_W   = 12,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                       aclk,
    input  logic                       areset,
    input  logic [ADDR_W-1:0]          s_axil_awaddr,
    input  logic [2:0]                 s_axil_awprot,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [DATA_W-1:0]          s_axil_wdata,
    input  logic [STRB_W-1:0]          s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,
    input  logic [ADDR_W-1:0]          s_axil_araddr,
    input  logic [2:0]                 s_axil_arprot,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [DATA_W-1:0]          s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,
    output logic [NUM_REGS*DATA_W-1:0] reg_out,
    output logic [NUM_REGS-1:0]        reg_wr_pulse,
    input  logic [DATA_W-1:0]          hw_status_in
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    // Protection bits and sub-word address bits carry no meaning here
    logic unused_c;
    assign unused_c = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

    // Write response for a given word index
    function automatic logic [1:0] wr_resp(input logic [IDX_W-1:0] idx);
        if (idx < IDX_W'(NUM_REGS)) begin
            return RESP_OKAY;
        end else if (idx == IDX_W'(NUM_REGS)) begin
`ifdef AXIL_REG_STICKY_STATUS_EN
            return RESP_OKAY;
`else
            return RESP_SLVERR;
`endif
        end
        return RESP_DECERR;
    endfunction

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t        wr_state_q, wr_state_d;
    logic [IDX_W-1:0] aw_idx_q, aw_idx_d;
    wr_beat_t         w_beat_q, w_beat_d;
    logic [1:0]       bresp_q, bresp_d;

    logic             aw_hs_c, w_hs_c, commit_c;
    logic [IDX_W-1:0] cm_idx_c;
    wr_beat_t         cm_beat_c;

    assign aw_hs_c = s_axil_awvalid && s_axil_awready;
    assign w_hs_c  = s_axil_wvalid && s_axil_wready;

    // Write state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            wr_state_q <= W_IDLE;
            aw_idx_q   <= '0;
            w_beat_q   <= '0;
            bresp_q    <= RESP_OKAY;
        end else begin
            wr_state_q <= wr_state_d;
            aw_idx_q   <= aw_idx_d;
            w_beat_q   <= w_beat_d;
            bresp_q    <= bresp_d;
        end
    end

    // Write next state; the commit picks live or latched halves of the pair
    always_comb begin
        wr_state_d = wr_state_q;
        aw_idx_d   = aw_idx_q;
        w_beat_d   = w_beat_q;
        bresp_d    = bresp_q;
        commit_c   = 1'b0;
        cm_idx_c   = aw_idx_q;
        cm_beat_c  = w_beat_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_c && w_hs_c) begin
                    commit_c  = 1'b1;
                    cm_idx_c  = s_axil_awaddr[ADDR_W-1:2];
                    cm_beat_c = '{data: s_axil_wdata, strb: s_axil_wstrb};
                end else if (aw_hs_c) begin
                    aw_idx_d   = s_axil_awaddr[ADDR_W-1:2];
                    wr_state_d = W_HAVE_ADDR;
                end else if (w_hs_c) begin
                    w_beat_d   = '{data: s_axil_wdata, strb: s_axil_wstrb};
                    wr_state_d = W_HAVE_DATA;
                end
            end
            W_HAVE_ADDR: begin
                if (w_hs_c) begin
                    commit_c  = 1'b1;
                    cm_beat_c = '{data: s_axil_wdata, strb: s_axil_wstrb};
                end
            end
            W_HAVE_DATA: begin
                if (aw_hs_c) begin
                    commit_c = 1'b1;
                    cm_idx_c = s_axil_awaddr[ADDR_W-1:2];
                end
            end
            W_RESP: begin
                if (s_axil_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
        endcase
        if (commit_c) begin
            wr_state_d = W_RESP;
            bresp_d    = wr_resp(cm_idx_c);
        end
    end

    // Write channel outputs; readies held low while in reset
    always_comb begin
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        if (!areset) begin
            case (wr_state_q)
                W_IDLE: begin
                    s_axil_awready = 1'b1;
                    s_axil_wready  = 1'b1;
                end
                W_HAVE_ADDR: s_axil_wready  = 1'b1;
                W_HAVE_DATA: s_axil_awready = 1'b1;
                W_RESP:      s_axil_bvalid  = 1'b1;
            endcase
        end
    end

    assign s_axil_bresp = bresp_q;

    // ------------------------------------------------------------------
    // Register bank
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] status_rd_c;

    axil_reg_bank #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .aclk         (aclk),
        .areset       (areset),
        .wr_en        (commit_c),
        .wr_idx       (cm_idx_c),
        .wr_beat      (cm_beat_c),
        .hw_status_in (hw_status_in),
        .reg_out      (reg_out),
        .reg_wr_pulse (reg_wr_pulse),
        .status_rd_c  (status_rd_c)
    );

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t         rd_state_q, rd_state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic [IDX_W-1:0]  ar_idx_c;
    logic [DATA_W-1:0] rd_data_c;
    logic [1:0]        rd_resp_c;

    assign ar_idx_c = s_axil_araddr[ADDR_W-1:2];

    // Read decode from pre-edge register contents, so a same-edge write
    // commit is not visible to this read
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_DECERR;
        if (ar_idx_c < IDX_W'(NUM_REGS)) begin
            rd_resp_c = RESP_OKAY;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (ar_idx_c == IDX_W'(i)) begin
                    rd_data_c = reg_out[DATA_W*i +: DATA_W];
                end
            end
        end else if (ar_idx_c == IDX_W'(NUM_REGS)) begin
            rd_resp_c = RESP_OKAY;
            rd_data_c = status_rd_c;
        end
    end

    // Read state register
    always_ff @(posedge aclk) begin
        if (areset) begin
            rd_state_q <= R_IDLE;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            rd_state_q <= rd_state_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    // Read next state
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: begin
                if (s_axil_arvalid && s_axil_arready) begin
                    rd_state_d = R_RESP;
                    rdata_d    = rd_data_c;
                    rresp_d    = rd_resp_c;
                end
            end
            R_RESP: begin
                if (s_axil_rready) begin
                    rd_state_d = R_IDLE;
                end
            end
        endcase
    end

    // Read channel outputs
    always_comb begin
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        if (!areset) begin
            case (rd_state_q)
                R_IDLE: s_axil_arready = 1'b1;
                R_RESP: s_axil_rvalid  = 1'b1;
            endcase
        end
    end

    assign s_axil_rdata = rdata_q;
    assign s_axil_rresp = rresp_q;

endmodule

// File: tb/tb_axil_reg_slave.sv
module tb_axil_reg_slave;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned NUM_REGS = 16;
`ifdef AXIL_REG_STICKY_STATUS_EN
    localparam bit STICKY = 1'b1;
`else
    localparam bit STICKY = 1'b0;
`endif

    logic                 aclk;
    logic                 areset;
    logic [ADDR_W-1:0]    awaddr;
    logic [2:0]           awprot;
    logic                 awvalid;
    logic                 awready;
    logic [31:0]          wdata;
    logic [3:0]           wstrb;
    logic                 wvalid;
    logic                 wready;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;
    logic [ADDR_W-1:0]    araddr;
    logic [2:0]           arprot;
    logic                 arvalid;
    logic                 arready;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic                 rvalid;
    logic                 rready;
    logic [NUM_REGS*32-1:0] reg_out;
    logic [NUM_REGS-1:0]  reg_wr_pulse;
    logic [31:0]          hw_status_in;

    axil_reg_slave #(.ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) dut (
        .aclk           (aclk),
        .areset         (areset),
        .s_axil_awaddr  (awaddr),
        .s_axil_awprot  (awprot),
        .s_axil_awvalid (awvalid),
        .s_axil_awready (awready),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wvalid  (wvalid),
        .s_axil_wready  (wready),
        .s_axil_bresp   (bresp),
        .s_axil_bvalid  (bvalid),
        .s_axil_bready  (bready),
        .s_axil_araddr  (araddr),
        .s_axil_arprot  (arprot),
        .s_axil_arvalid (arvalid),
        .s_axil_arready (arready),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rvalid  (rvalid),
        .s_axil_rready  (rready),
        .reg_out        (reg_out),
        .reg_wr_pulse   (reg_wr_pulse),
        .hw_status_in   (hw_status_in)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: plain array of registers plus the status word
    logic [31:0] mdl_regs [NUM_REGS];
    logic [31:0] mdl_status;

    function automatic logic [511:0] mdl_flat();
        logic [511:0] f;
        f = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) f[32*i +: 32] = mdl_regs[i];
        return f;
    endfunction

    task automatic mdl_reset();
        for (int i = 0; i < int'(NUM_REGS); i++) mdl_regs[i] = 32'h0;
        mdl_status = STICKY ? 32'h0 : hw_status_in;
    endtask

    function automatic logic [1:0] mdl_wresp(input int idx);
        if (idx < int'(NUM_REGS)) return 2'b00;
        if (idx == int'(NUM_REGS)) return STICKY ? 2'b00 : 2'b10;
        return 2'b11;
    endfunction

    task automatic mdl_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        if (idx < int'(NUM_REGS)) begin
            for (int k = 0; k < 4; k++) if (s[k]) mdl_regs[idx][8*k +: 8] = d[8*k +: 8];
        end else if (idx == int'(NUM_REGS) && STICKY) begin
            for (int k = 0; k < 4; k++) if (s[k]) mdl_status[8*k +: 8] = mdl_status[8*k +: 8] & ~d[8*k +: 8];
            mdl_status = mdl_status | hw_status_in;
        end
    endtask

    function automatic logic [15:0] mdl_pulse(input int idx, input logic [3:0] s);
        logic [15:0] p;
        p = '0;
        if (idx < int'(NUM_REGS) && s != 4'h0) p[idx] = 1'b1;
        return p;
    endfunction

    task automatic mdl_read(input int idx, output logic [31:0] d, output logic [1:0] r);
        if (idx < int'(NUM_REGS)) begin d = mdl_regs[idx]; r = 2'b00; end
        else if (idx == int'(NUM_REGS)) begin d = mdl_status; r = 2'b00; end
        else begin d = 32'h0; r = 2'b11; end
    endtask

    // Change hardware status between transactions and let one edge pass
    task automatic set_hw(input logic [31:0] v);
        hw_status_in = v;
        @(posedge aclk); #1;
        mdl_status = STICKY ? (mdl_status | v) : v;
    endtask

    task automatic do_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output logic [15:0] p1, output logic [15:0] p2);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        awaddr = a; wdata = d; wstrb = s;
        while (!(aw_done && w_done) && cyc < 40) begin
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge aclk); #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        awvalid = 0; wvalid = 0;
        chk("w_handshakes", {aw_done, w_done}, 2'b11);
        chk("b_rise", {bvalid, awready, wready}, 3'b100);
        resp = bresp;
        p1 = reg_wr_pulse;
        p2 = 16'hFFFF;
        for (int i = 0; i < b_dly; i++) begin
            @(posedge aclk); #1;
            if (i == 0) p2 = reg_wr_pulse;
            chk("b_hold", {bvalid, awready, wready, bresp}, {3'b100, resp});
        end
        bready = 1;
        @(posedge aclk); #1;
        bready = 0;
        if (b_dly == 0) p2 = reg_wr_pulse;
        chk("b_done", bvalid, 1'b0);
    endtask

    task automatic do_read(input logic [11:0] a, input int r_dly, output logic [31:0] d, output logic [1:0] r);
        int cyc = 0;
        araddr = a; arvalid = 1;
        while (!arready && cyc < 20) begin @(posedge aclk); #1; cyc++; end
        chk("ar_ready", arready, 1'b1);
        @(posedge aclk); #1;
        arvalid = 0;
        chk("r_rise", {rvalid, arready}, 2'b10);
        d = rdata; r = rresp;
        for (int i = 0; i < r_dly; i++) begin
            @(posedge aclk); #1;
            chk("r_hold", {rvalid, arready, rdata, rresp}, {2'b10, d, r});
        end
        rready = 1;
        @(posedge aclk); #1;
        rready = 0;
    endtask

    typedef struct {
        bit          rd;
        logic [11:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          d1;
        int          d2;
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic [15:0] exp_pulse;
    } vec_t;

    function automatic vec_t mk(bit rd, logic [11:0] a, logic [31:0] d, logic [3:0] s,
                                int d1, int d2, logic [1:0] er, logic [31:0] ed, logic [15:0] ep);
        vec_t v;
        v.rd = rd; v.addr = a; v.data = d; v.strb = s; v.d1 = d1; v.d2 = d2;
        v.exp_resp = er; v.exp_rdata = ed; v.exp_pulse = ep;
        return v;
    endfunction

    vec_t vecs [16];

    initial begin
        logic [1:0]  resp;
        logic [15:0] p1, p2;
        logic [31:0] d, ed;
        logic [1:0]  er;

        // Directed table: writes use d1/d2 as AW/W delays, reads use d1 as rready delay
        vecs[0]  = mk(0, 12'h004, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 32'h0, 16'h0002);
        vecs[1]  = mk(0, 12'h008, 32'hAAAAAAAA, 4'hF, 0, 0, 2'b00, 32'h0, 16'h0004);
        vecs[2]  = mk(0, 12'h008, 32'h11223344, 4'h5, 3, 0, 2'b00, 32'h0, 16'h0004);
        vecs[3]  = mk(1, 12'h008, 32'h0,        4'h0, 0, 0, 2'b00, 32'hAA22AA44, 16'h0);
        vecs[4]  = mk(1, 12'h004, 32'h0,        4'h0, 4, 0, 2'b00, 32'hDEADBEEF, 16'h0);
        vecs[5]  = mk(0, 12'h040, 32'h12345678, 4'hF, 0, 0, STICKY ? 2'b00 : 2'b10, 32'h0, 16'h0);
        vecs[6]  = mk(0, 12'h100, 32'h55555555, 4'hF, 1, 0, 2'b11, 32'h0, 16'h0);
        vecs[7]  = mk(1, 12'h100, 32'h0,        4'h0, 1, 0, 2'b11, 32'h0, 16'h0);
        vecs[8]  = mk(1, 12'h040, 32'h0,        4'h0, 0, 0, 2'b00, 32'h0, 16'h0);
        vecs[9]  = mk(0, 12'h03C, 32'hFFFFFFFF, 4'h0, 0, 0, 2'b00, 32'h0, 16'h0);
        vecs[10] = mk(0, 12'h03C, 32'h87654321, 4'h8, 0, 2, 2'b00, 32'h0, 16'h8000);
        vecs[11] = mk(1, 12'h03C, 32'h0,        4'h0, 2, 0, 2'b00, 32'h87000000, 16'h0);
        vecs[12] = mk(1, 12'h000, 32'h0,        4'h0, 0, 0, 2'b00, 32'h0, 16'h0);
        vecs[13] = mk(0, 12'h007, 32'h0000FFFF, 4'h3, 1, 1, 2'b00, 32'h0, 16'h0002);
        vecs[14] = mk(1, 12'h005, 32'h0,        4'h0, 0, 0, 2'b00, 32'hDEADFFFF, 16'h0);
        vecs[15] = mk(0, 12'h044, 32'h01010101, 4'hF, 2, 1, 2'b11, 32'h0, 16'h0);

        areset = 1; awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
        bready = 0; araddr = '0; arprot = '0; arvalid = 0; rready = 0; hw_status_in = '0;

        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        chk("rst_readies", {awready, wready, arready}, 3'b000);
        chk("rst_valids", {bvalid, rvalid}, 2'b00);
        areset = 0;
        #1;
        mdl_reset();
        chk("post_rst_readies", {awready, wready, arready}, 3'b111);
        chk("post_rst_outs", {bresp, rresp, rdata, reg_wr_pulse}, '0);
        chk("post_rst_regs", reg_out, mdl_flat());

        // Directed table
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].rd) begin
                do_read(vecs[i].addr, vecs[i].d1, d, resp);
                chk($sformatf("tbl%0d_rdata", i), d, vecs[i].exp_rdata);
                chk($sformatf("tbl%0d_rresp", i), resp, vecs[i].exp_resp);
            end else begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].d1, vecs[i].d2, i % 3, resp, p1, p2);
                mdl_write(int'(vecs[i].addr[11:2]), vecs[i].data, vecs[i].strb);
                chk($sformatf("tbl%0d_bresp", i), resp, vecs[i].exp_resp);
                chk($sformatf("tbl%0d_pulse", i), p1, vecs[i].exp_pulse);
                chk($sformatf("tbl%0d_pulse_end", i), p2, 16'h0);
                chk($sformatf("tbl%0d_regs", i), reg_out, mdl_flat());
            end
        end

        // No AW/W acceptance on the B handshake edge
        awaddr = 12'h00C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        @(posedge aclk); #1;
        mdl_write(3, 32'h1, 4'hF);
        chk("seqd_commit", {bvalid, reg_out[127:96]}, {1'b1, 32'h1});
        wdata = 32'h2; bready = 1;
        @(posedge aclk); #1;
        bready = 0;
        chk("seqd_no_accept", {bvalid, awready, wready, reg_out[127:96]}, {3'b011, 32'h1});
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0;
        mdl_write(3, 32'h2, 4'hF);
        chk("seqd_second", {bvalid, reg_out[127:96]}, {1'b1, 32'h2});
        bready = 1; @(posedge aclk); #1; bready = 0;

        // AR on the same edge as a write commit to the same register
        ed = mdl_regs[1];
        awaddr = 12'h004; wdata = 32'h0; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        araddr = 12'h004; arvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0; wvalid = 0; arvalid = 0;
        mdl_write(1, 32'h0, 4'hF);
        chk("seqe_rdata_old", {rvalid, bvalid, rdata}, {2'b11, ed});
        chk("seqe_regs", reg_out, mdl_flat());
        bready = 1; rready = 1; @(posedge aclk); #1; bready = 0; rready = 0;
        do_read(12'h004, 0, d, resp);
        chk("seqe_rdata_new", d, 32'h0);

        // Reset in the middle of a write (address latched) and a read response
        awaddr = 12'h00C; awvalid = 1; araddr = 12'h004; arvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0; arvalid = 0;
        chk("seqf_pre", {rvalid, awready, wready}, 3'b101);
        areset = 1;
        @(posedge aclk); #1;
        chk("seqf_rst_ctrl", {rvalid, bvalid, awready, wready, arready}, 5'b0);
        chk("seqf_rst_data", {rdata, rresp, bresp, reg_wr_pulse}, '0);
        chk("seqf_rst_regs", reg_out, 512'h0);
        areset = 0;
        #1;
        mdl_reset();
        wdata = 32'h55; wstrb = 4'hF; wvalid = 1;
        @(posedge aclk); #1;
        wvalid = 0;
        chk("seqf_no_stale_addr", {bvalid, awready, wready}, 3'b010);
        @(posedge aclk); #1;
        chk("seqf_wait_addr", bvalid, 1'b0);
        awaddr = 12'h010; awvalid = 1;
        @(posedge aclk); #1;
        awvalid = 0;
        mdl_write(4, 32'h55, 4'hF);
        chk("seqf_commit", {bvalid, bresp, reg_wr_pulse}, {1'b1, 2'b00, 16'h0010});
        chk("seqf_regs", reg_out, mdl_flat());
        bready = 1; @(posedge aclk); #1; bready = 0;

`ifdef AXIL_REG_STICKY_STATUS_EN
        // Sticky status: set by a one-cycle pulse, W1C, set wins over clear
        set_hw(32'h1);
        set_hw(32'h0);
        do_read(12'h040, 0, d, resp);
        chk("sticky_set", {resp, d}, {2'b00, 32'h1});
        do_write(12'h040, 32'h1, 4'hF, 0, 0, 0, resp, p1, p2);
        mdl_write(16, 32'h1, 4'hF);
        chk("sticky_w1c_resp", {resp, p1}, {2'b00, 16'h0});
        do_read(12'h040, 0, d, resp);
        chk("sticky_cleared", d, 32'h0);
        set_hw(32'h1);
        do_write(12'h040, 32'h1, 4'hF, 0, 0, 0, resp, p1, p2);
        mdl_write(16, 32'h1, 4'hF);
        do_read(12'h040, 0, d, resp);
        chk("sticky_set_wins", d, 32'h1);
        set_hw(32'h0);
`endif

        // Randomized traffic against the reference model
        for (int n = 0; n < 240; n++) begin
            int idx;
            logic [11:0] a;
            logic [31:0] wd;
            logic [3:0]  ws;
            if (n % 16 == 0) set_hw($urandom);
            idx = ($urandom_range(0, 9) == 0) ? int'($urandom_range(17, 1023)) : int'($urandom_range(0, 16));
            a = {idx[9:0], 2'($urandom)};
            if ($urandom_range(0, 1) == 0) begin
                wd = $urandom;
                ws = 4'($urandom);
                do_write(a, wd, ws, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 2)), resp, p1, p2);
                chk("rnd_bresp", resp, mdl_wresp(idx));
                chk("rnd_pulse", p1, mdl_pulse(idx, ws));
                chk("rnd_pulse_end", p2, 16'h0);
                mdl_write(idx, wd, ws);
                chk("rnd_regs", reg_out, mdl_flat());
            end else begin
                mdl_read(idx, ed, er);
                do_read(a, int'($urandom_range(0, 2)), d, resp);
                chk("rnd_rdata", d, ed);
                chk("rnd_rresp", resp, er);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
